// File: rtl/tm_pio_mem_resp.sv
// Memory-side PIO responder for one TM configuration table.
// Arbitrates single-port RAM access with the scheduler datapath; handshakes mem_ack on clk_div.
module tm_pio_mem_resp #(
  parameter int ADDR_NBITS   = 10,
  parameter int DATA_NBITS   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_div,
  input  logic                  reg_ms,
  input  logic                  reg_wr,
  input  logic                  reg_rd,
  input  logic [ADDR_NBITS-1:0] reg_addr,
  input  logic [DATA_NBITS-1:0] reg_din,
  output logic                  mem_ack,
  output logic [DATA_NBITS-1:0] mem_rdata,
  output logic                  pio_overrun,
  input  logic                  dp_busy,
  output logic                  pio_hold,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [ADDR_NBITS-1:0] ram_addr,
  output logic [DATA_NBITS-1:0] ram_wdata,
  input  logic [DATA_NBITS-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RDWAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] LAT   = 2'(RD_LATENCY);

  state_t                state;
  logic [ADDR_NBITS-1:0] addr_q;
  logic [DATA_NBITS-1:0] din_q;
  logic                  op_wr;
  logic [3:0]            wait_cnt;
  logic [1:0]            lat_cnt;
  logic                  strobe;
  logic [3:0]            cnt_inc;

  assign strobe    = reg_ms & (reg_rd | reg_wr);
  assign cnt_inc   = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
  assign ram_addr  = addr_q;
  assign ram_wdata = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      op_wr       <= 1'b0;
      wait_cnt    <= '0;
      lat_cnt     <= '0;
      mem_ack     <= 1'b0;
      mem_rdata   <= '0;
      pio_overrun <= 1'b0;
      pio_hold    <= 1'b0;
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      ram_wr <= 1'b0;
      if (strobe && state != S_IDLE) pio_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (strobe) begin
            addr_q <= reg_addr;
            din_q  <= reg_din;
            op_wr  <= reg_wr;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!dp_busy) begin
            ram_wr <= op_wr;
            ram_rd <= ~op_wr;
            state  <= S_ACCESS;
          end else begin
            // hold tracks the saturated count, so it is already correct entering ACCESS
            wait_cnt <= cnt_inc;
            pio_hold <= (cnt_inc >= LIMIT);
          end
        end
        S_ACCESS: begin
          pio_hold <= 1'b0;
          if (op_wr) begin
            mem_ack <= 1'b1;
            state   <= S_DONE;
          end else begin
            lat_cnt <= 2'd1;
            state   <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (lat_cnt == LAT) begin
            mem_rdata <= ram_rdata;
            mem_ack   <= 1'b1;
            state     <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (clk_div) begin
            mem_ack  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
